// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ requesters.
// Each grant runs IDLE -> CAPTURE -> RESP, so at most one read is in flight.
module regfile_read_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            ReqValid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] ReqAddr,
    output logic [NUM_REQ-1:0]            ReqReady,
    output logic [ADDR_WIDTH-1:0]         PortAddress,
    input  logic [DATA_WIDTH-1:0]         PortData,
    output logic [NUM_REQ-1:0]            RespValid,
    input  logic [NUM_REQ-1:0]            RespReady,
    output logic [DATA_WIDTH-1:0]         RespData,
    output logic                          Busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic                    grant_found;
    logic [PTR_W-1:0]        winner;
    logic [NUM_REQ-1:0]      req_ready_c;
    logic [NUM_REQ-1:0]      resp_valid_c;

    // Rotating priority search starting at the pointer.
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        winner      = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && ReqValid[PTR_W'(idx)]) begin
                grant_found = 1'b1;
                winner      = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        data_d       = data_q;
        req_ready_c  = '0;
        resp_valid_c = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready_c[winner] = 1'b1;
                    addr_d              = ReqAddr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                    owner_d             = winner;
                    ptr_d               = (32'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);
                    state_d             = CAPTURE;
                end
            end
            CAPTURE: begin
                data_d  = PortData;
                state_d = RESP;
            end
            RESP: begin
                resp_valid_c[owner_q] = 1'b1;
                if (RespReady[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Strobes are forced low for the whole time Reset is high, not just after the edge.
    assign ReqReady    = Reset ? '0 : req_ready_c;
    assign RespValid   = Reset ? '0 : resp_valid_c;
    assign Busy        = !Reset && (state_q != IDLE);
    assign PortAddress = addr_q;
    assign RespData    = data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scenario bench for regfile_read_arbiter: a behavioural round-robin model feeds a
// scoreboard of expected responses that is checked when RespValid appears.
module tb_regfile_read_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  ReqValid;
    logic [19:0] ReqAddr;
    logic [3:0]  ReqReady;
    logic [4:0]  PortAddress;
    logic [31:0] PortData;
    logic [3:0]  RespValid;
    logic [3:0]  RespReady;
    logic [31:0] RespData;
    logic        Busy;

    logic [4:0]  addr_tb [4];
    logic        pd_override;

    typedef struct {
        int          owner;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tb_ptr   = 0;

    always #5 Clk = ~Clk;

    assign ReqAddr  = {addr_tb[3], addr_tb[2], addr_tb[1], addr_tb[0]};
    // Register-file model: each register holds its own address unless overridden.
    assign PortData = pd_override ? 32'hDEADBEEF : 32'(PortAddress);

    regfile_read_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ReqValid   (ReqValid),
        .ReqAddr    (ReqAddr),
        .ReqReady   (ReqReady),
        .PortAddress(PortAddress),
        .PortData   (PortData),
        .RespValid  (RespValid),
        .RespReady  (RespReady),
        .RespData   (RespData),
        .Busy       (Busy)
    );

    task automatic do_reset();
        Reset     = 1'b1;
        ReqValid  = '0;
        RespReady = '0;
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;
        sb.delete();
        tb_ptr = 0;
    endtask

    task automatic test_reset();
        Reset       = 1'b1;
        ReqValid    = 4'b1111;
        RespReady   = 4'b1111;
        pd_override = 1'b0;
        for (int i = 0; i < 4; i++) addr_tb[i] = 5'(i + 1);
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if (ReqReady !== 4'b0000 || RespValid !== 4'b0000 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: ReqReady=%b RespValid=%b Busy=%b, required 0000 0000 0",
                     ReqReady, RespValid, Busy);
        end
        n_checks++;
        if (PortAddress !== 5'd0 || RespData !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs: PortAddress=%0d RespData=%h, required 0 and 0", PortAddress, RespData);
        end
        #1 Reset = 1'b0;
        ReqValid = '0;
        sb.delete();
        tb_ptr = 0;
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        addr_tb[2] = 5'd20;
        ReqValid   = 4'b0100;
        @(negedge Clk);
        n_checks++;
        if (ReqReady !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: ReqReady=%b, required 0100", ReqReady);
        end
        e.owner = 2;
        e.data  = 32'd20;
        sb.push_back(e);
        @(posedge Clk);
        #1 ReqValid = '0;
        @(negedge Clk);
        n_checks++;
        if (RespValid !== 4'b0000 || Busy !== 1'b1 || ReqReady !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_capture: RespValid=%b Busy=%b ReqReady=%b, required 0000 1 0000",
                     RespValid, Busy, ReqReady);
        end
        @(posedge Clk);
        #1 RespReady = 4'b1111;
        @(negedge Clk);
        e = sb.pop_front();
        n_checks++;
        if (RespValid !== (4'b0001 << e.owner) || RespData !== e.data) begin
            n_fail++;
            $display("FAIL single_resp: RespValid=%b RespData=%0d, required %b %0d",
                     RespValid, RespData, 4'b0001 << e.owner, e.data);
        end
        @(negedge Clk);
        n_checks++;
        if (Busy !== 1'b0 || RespValid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_done: Busy=%b RespValid=%b, required 0 0000", Busy, RespValid);
        end
        tb_ptr = 3;
    endtask

    // Holds `valid` until n_resp reads finish; the model predicts every grant and response.
    task automatic test_arbitration(input logic [3:0] valid, input int n_resp);
        int         mstate = 0;
        int         done   = 0;
        int         w;
        logic [3:0] oh;
        exp_t       e;
        ReqValid  = valid;
        RespReady = 4'b1111;
        for (int cyc = 0; cyc < n_resp * 3 + 6 && done < n_resp; cyc++) begin
            @(negedge Clk);
            if (mstate == 0) begin
                if (ReqValid != 4'b0000) begin
                    w = -1;
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && ReqValid[(tb_ptr + k) % 4]) w = (tb_ptr + k) % 4;
                    oh = 4'b0001 << w;
                    n_checks++;
                    if (ReqReady !== oh) begin
                        n_fail++;
                        $display("FAIL arb_grant: ReqReady=%b, required %b", ReqReady, oh);
                    end
                    e.owner = w;
                    e.data  = 32'(addr_tb[w]);
                    sb.push_back(e);
                    tb_ptr = (w + 1) % 4;
                    mstate = 1;
                end
            end else if (mstate == 1) begin
                n_checks++;
                if (RespValid !== 4'b0000 || ReqReady !== 4'b0000 || Busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL arb_capture: RespValid=%b ReqReady=%b Busy=%b, required 0000 0000 1",
                             RespValid, ReqReady, Busy);
                end
                mstate = 2;
            end else begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL arb_scoreboard: empty in response phase, required one entry");
                    mstate = 0;
                end else begin
                    e  = sb[0];
                    oh = 4'b0001 << e.owner;
                    n_checks++;
                    if (RespValid !== oh || RespData !== e.data) begin
                        n_fail++;
                        $display("FAIL arb_resp: RespValid=%b RespData=%0d, required %b %0d",
                                 RespValid, RespData, oh, e.data);
                    end
                    if (RespReady[e.owner]) begin
                        void'(sb.pop_front());
                        done++;
                        mstate = 0;
                    end
                end
            end
            @(posedge Clk);
            #1;
            if (done == n_resp) ReqValid = '0;
        end
        n_checks++;
        if (done != n_resp) begin
            n_fail++;
            $display("FAIL arb_timeout: %0d responses, required %0d", done, n_resp);
        end
        ReqValid = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        addr_tb[0] = 5'd3;
        addr_tb[1] = 5'd10;
        addr_tb[2] = 5'd17;
        addr_tb[3] = 5'd24;
        test_arbitration(4'b1111, 5);
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        addr_tb[0] = 5'd6;
        addr_tb[2] = 5'd12;
        addr_tb[3] = 5'd29;
        test_arbitration(4'b0100, 1);
        n_checks++;
        if (tb_ptr != 3) begin
            n_fail++;
            $display("FAIL wrap_setup: model pointer=%0d, required 3", tb_ptr);
        end
        test_arbitration(4'b1001, 2);
    endtask

    task automatic test_stall();
        exp_t e;
        do_reset();
        addr_tb[1] = 5'd9;
        ReqValid   = 4'b0010;
        @(negedge Clk);
        n_checks++;
        if (ReqReady !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_grant: ReqReady=%b, required 0010", ReqReady);
        end
        e.owner = 1;
        e.data  = 32'd9;
        sb.push_back(e);
        @(posedge Clk);
        #1 ReqValid = 4'b1111;
        RespReady   = 4'b1101;
        @(posedge Clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 3) RespReady = 4'b0010;
            @(negedge Clk);
            n_checks++;
            if (RespValid !== 4'b0010 || RespData !== sb[0].data || ReqReady !== 4'b0000 || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: RespValid=%b RespData=%0d ReqReady=%b Busy=%b, required 0010 %0d 0000 1",
                         i, RespValid, RespData, ReqReady, Busy, sb[0].data);
            end
            @(posedge Clk);
        end
        void'(sb.pop_front());
        @(negedge Clk);
        n_checks++;
        if (Busy !== 1'b0 || RespValid !== 4'b0000 || ReqReady !== 4'b0100) begin
            n_fail++;
            $display("FAIL stall_release: Busy=%b RespValid=%b ReqReady=%b, required 0 0000 0100",
                     Busy, RespValid, ReqReady);
        end
        ReqValid = '0;
    endtask

    task automatic test_reset_capture();
        do_reset();
        addr_tb[0] = 5'd7;
        addr_tb[1] = 5'd15;
        test_arbitration(4'b0001, 1);
        ReqValid = 4'b0010;
        @(negedge Clk);
        n_checks++;
        if (ReqReady !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstcap_grant: ReqReady=%b, required 0010", ReqReady);
        end
        @(posedge Clk);
        #1 ReqValid = '0;
        Reset = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (Busy !== 1'b0 || RespValid !== 4'b0000 || ReqReady !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstcap_during: Busy=%b RespValid=%b ReqReady=%b, required 0 0000 0000",
                     Busy, RespValid, ReqReady);
        end
        @(posedge Clk);
        #1 Reset = 1'b0;
        sb.delete();
        tb_ptr = 0;
        @(negedge Clk);
        n_checks++;
        if (RespValid !== 4'b0000 || RespData !== 32'd0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstcap_after: RespValid=%b RespData=%h Busy=%b, required 0000 0 0",
                     RespValid, RespData, Busy);
        end
        @(negedge Clk);
        n_checks++;
        if (RespValid !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstcap_noresp: RespValid=%b, required 0000", RespValid);
        end
        @(posedge Clk);
        #1;
        test_arbitration(4'b1111, 1);
    endtask

    task automatic test_boundary();
        logic [4:0] baddr [2];
        int         breq  [2];
        baddr[0] = 5'd0;
        baddr[1] = 5'd31;
        breq[0]  = 3;
        breq[1]  = 0;
        do_reset();
        pd_override = 1'b1;
        for (int t = 0; t < 2; t++) begin
            addr_tb[breq[t]] = baddr[t];
            ReqValid  = 4'b0001 << breq[t];
            RespReady = 4'b1111;
            @(negedge Clk);
            @(posedge Clk);
            #1 ReqValid = '0;
            @(posedge Clk);
            @(negedge Clk);
            n_checks++;
            if (RespData !== 32'hDEADBEEF || PortAddress !== baddr[t] || RespValid !== (4'b0001 << breq[t])) begin
                n_fail++;
                $display("FAIL boundary_addr%0d: RespData=%h PortAddress=%0d RespValid=%b, required deadbeef %0d %b",
                         baddr[t], RespData, PortAddress, RespValid, 32'hDEADBEEF, baddr[t], 4'b0001 << breq[t]);
            end
            @(posedge Clk);
            #1;
        end
        pd_override = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_stall();
        test_reset_capture();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
